// File: rtl/step_pkg.sv
// Shared types and constants for the step controller.
package step_pkg;

    // FSM state encoding; values 5-7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_REL  = 3'd3,
        HALTED    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized level.
module sync_edge (
    input  logic C_50Mhz,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic ff1_q;
    logic ff2_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge C_50Mhz) begin
        if (rst) begin
            ff1_q  <= 1'b0;
            ff2_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            ff1_q  <= d;
            ff2_q  <= ff1_q;
            prev_q <= ff2_q;
        end
    end

    assign q    = ff2_q;
    assign rise = ff2_q & ~prev_q;

endmodule

// File: rtl/step_controller.sv
// Turns the 1 kHz divider output into step enables for the processor, in run
// or single-step mode, with a tick-paced debounce of the step pushbutton.
module step_controller
    import step_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEB_TICKS = 4,
    parameter int unsigned DEB_W     = 3
) (
    input  logic             C_50Mhz,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             halted_in,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic [2:0]       state_o,
    output logic             halted_o
);

    // The counter flips the level on the increment that would reach DEB_TICKS.
    localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_TICKS - 1);

    logic tick_pulse;
    logic tick_lvl_unused;
    logic btn_s;
    logic btn_rise_unused;

    logic [DEB_W-1:0] deb_cnt_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic             press_pulse;
    logic             release_pulse;

    state_t           state_q;
    logic             step_en_q;
    logic             halted_q;
    logic [CNT_W-1:0] step_count_q;

    sync_edge u_tick_sync (
        .C_50Mhz (C_50Mhz),
        .rst     (rst),
        .d       (tick_in),
        .q       (tick_lvl_unused),
        .rise    (tick_pulse)
    );

    sync_edge u_btn_sync (
        .C_50Mhz (C_50Mhz),
        .rst     (rst),
        .d       (step_btn),
        .q       (btn_s),
        .rise    (btn_rise_unused)
    );

    // Debounce: sample the button once per tick, flip after DEB_TICKS disagreeing samples.
    always_ff @(posedge C_50Mhz) begin
        if (rst) begin
            deb_cnt_q  <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            deb_prev_q <= deb_q;
            if (tick_pulse) begin
                if (btn_s != deb_q) begin
                    if (deb_cnt_q == DebLast) begin
                        deb_q     <= ~deb_q;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_q <= '0;
                end
            end
        end
    end

    assign press_pulse   = deb_q & ~deb_prev_q;
    assign release_pulse = ~deb_q & deb_prev_q;

    // Step FSM; halt beats a mode change, which beats a tick or press.
    always_ff @(posedge C_50Mhz) begin
        if (rst) begin
            state_q   <= IDLE;
            step_en_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            halted_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mode == MODE_RUN) begin
                        state_q <= RUN;
                    end else if (mode == MODE_STEP) begin
                        state_q <= STEP_WAIT;
                    end
                end
                RUN: begin
                    if (halted_in) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (mode != MODE_RUN) begin
                        state_q <= IDLE;
                    end else if (tick_pulse) begin
                        step_en_q <= 1'b1;
                    end
                end
                STEP_WAIT: begin
                    if (halted_in) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (mode != MODE_STEP) begin
                        state_q <= IDLE;
                    end else if (press_pulse) begin
                        step_en_q <= 1'b1;
                        state_q   <= STEP_REL;
                    end
                end
                STEP_REL: begin
                    // No step here: a held button yields exactly one step.
                    if (halted_in) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (mode != MODE_STEP) begin
                        state_q <= IDLE;
                    end else if (release_pulse) begin
                        state_q <= STEP_WAIT;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of issued steps.
    always_ff @(posedge C_50Mhz) begin
        if (rst) begin
            step_count_q <= '0;
        end else if (step_en_q && (step_count_q != '1)) begin
            step_count_q <= step_count_q + 1'b1;
        end
    end

    assign step_en    = step_en_q;
    assign step_count = step_count_q;
    assign state_o    = state_q;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_step_controller.sv
// Randomized bench for step_controller with a behavioural reference model.
module tb_step_controller;

    localparam int CNT_W     = 4;
    localparam int DEB_TICKS = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic [1:0]       mode;
    logic             step_btn;
    logic             halted_in;
    logic             step_en;
    logic [CNT_W-1:0] step_count;
    logic [2:0]       state_o;
    logic             halted_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    step_controller #(
        .CNT_W     (CNT_W),
        .DEB_TICKS (DEB_TICKS),
        .DEB_W     (3)
    ) dut (
        .C_50Mhz    (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .mode       (mode),
        .step_btn   (step_btn),
        .halted_in  (halted_in),
        .step_en    (step_en),
        .step_count (step_count),
        .state_o    (state_o),
        .halted_o   (halted_o)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // th/bh hold the last samples of tick_in/step_btn, newest first.
    int m_state = 0;
    int m_count = 0;
    int m_deb_cnt = 0;
    bit m_en = 0;
    bit m_deb = 0;
    bit m_deb_prev = 0;
    bit th[3];
    bit bh[2];

    function automatic int mode_for(input int s);
        return (s == 1) ? 1 : 2;
    endfunction

    always @(posedge clk) begin
        bit tp, prs, rel, nen;
        int ns;
        if (rst) begin
            m_state = 0; m_count = 0; m_deb_cnt = 0;
            m_en = 0; m_deb = 0; m_deb_prev = 0;
            th = '{0, 0, 0}; bh = '{0, 0};
        end else begin
            tp  = th[1] && !th[2];
            prs = m_deb && !m_deb_prev;
            rel = !m_deb && m_deb_prev;
            if (m_en && m_count < CNT_MAX) m_count = m_count + 1;
            nen = 0;
            ns  = m_state;
            if (m_state == 4) ns = 4;
            else if (m_state > 4) ns = 0;
            else if (m_state != 0 && halted_in) ns = 4;
            else if (m_state == 0) ns = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
            else if (int'(mode) != mode_for(m_state)) ns = 0;
            else if (m_state == 1) nen = tp;
            else if (m_state == 2 && prs) begin nen = 1; ns = 3; end
            else if (m_state == 3 && rel) ns = 2;
            m_deb_prev = m_deb;
            if (tp) begin
                if (bh[1] != m_deb) begin
                    m_deb_cnt = m_deb_cnt + 1;
                    if (m_deb_cnt == DEB_TICKS) begin m_deb = !m_deb; m_deb_cnt = 0; end
                end else begin
                    m_deb_cnt = 0;
                end
            end
            th[2] = th[1]; th[1] = th[0]; th[0] = tick_in;
            bh[1] = bh[0]; bh[0] = step_btn;
            m_state = ns;
            m_en = nen;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("step_en", int'(step_en), int'(m_en));
        check("step_count", int'(step_count), m_count);
        check("state", int'(state_o), m_state);
        check("halted_o", int'(halted_o), int'(m_state == 4));
    end

    // ---------------- tick generator ----------------
    bit tick_run = 0;
    int rises = 0;
    int ph_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (tick_run) begin
            if (ph_cnt == 0) begin
                tick_in = ~tick_in;
                if (tick_in) rises++;
                ph_cnt = $urandom_range(6, 14);
            end else begin
                ph_cnt--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int start, k;
        start = rises;
        k = 0;
        while (rises < start + n && k < budget) begin
            cyc(1);
            k++;
        end
        check("tick_rises_within_budget", rises - start, n);
    endtask

    task automatic wait_state(input int s, input int budget);
        int k;
        k = 0;
        while (int'(state_o) != s && k < budget) begin
            cyc(1);
            k++;
        end
        check("reach_state", int'(state_o), s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; mode = 2'b00; tick_in = 1'b0; step_btn = 1'b0; halted_in = 1'b0;
        cyc(2);
        @(negedge clk);
        check("reset_state", int'(state_o), 0);
        check("reset_count", int'(step_count), 0);
        check("reset_step_en", int'(step_en), 0);
        check("reset_halted", int'(halted_o), 0);
        cyc(1);
        rst = 1'b0;

        // Run mode: one step per tick rising edge.
        mode = 2'b01;
        tick_run = 1;
        wait_rises(5, 400);
        tick_run = 0;
        cyc(4);
        @(negedge clk);
        check("run_count_5", int'(step_count), 5);
        check("model_run_count_5", m_count, 5);
        cyc(1);
        tick_in = 1'b0;
        mode = 2'b00;
        cyc(3);

        // Single step with a bouncing button.
        do_reset();
        mode = 2'b10;
        tick_run = 1;
        repeat (8) begin
            step_btn = ~step_btn;
            cyc($urandom_range(1, 3));
        end
        step_btn = 1'b1;
        wait_rises(8, 400);
        @(negedge clk);
        check("bounce_state_rel", int'(state_o), 3);
        cyc(1);
        step_btn = 1'b0;
        wait_rises(8, 400);
        @(negedge clk);
        check("bounce_state_wait", int'(state_o), 2);
        check("bounce_count_1", int'(step_count), 1);
        check("model_bounce_count_1", m_count, 1);
        cyc(1);

        // Button held for many debounce periods.
        do_reset();
        mode = 2'b10;
        step_btn = 1'b1;
        wait_rises(30, 1200);
        @(negedge clk);
        check("held_state", int'(state_o), 3);
        check("held_count_1", int'(step_count), 1);
        cyc(1);
        step_btn = 1'b0;
        wait_rises(8, 400);
        @(negedge clk);
        check("held_release_state", int'(state_o), 2);
        cyc(1);

        // Halt coinciding with a tick pulse in RUN.
        tick_run = 0;
        cyc(2);
        tick_in = 1'b0;
        do_reset();
        mode = 2'b01;
        cyc(4);
        tick_in = 1'b1;
        cyc(2);
        halted_in = 1'b1;
        cyc(1);
        halted_in = 1'b0;
        @(negedge clk);
        check("halt_no_step", int'(step_en), 0);
        check("halt_state", int'(state_o), 4);
        check("halt_flag", int'(halted_o), 1);
        check("model_halt_state", m_state, 4);
        cyc(1);
        mode = 2'b10;
        cyc(5);
        mode = 2'b00;
        tick_run = 1;
        wait_rises(3, 200);
        @(negedge clk);
        check("halt_sticky_state", int'(state_o), 4);
        check("halt_sticky_count", int'(step_count), 0);
        cyc(1);

        // Mode change while in STEP_REL, then mode 11 in RUN.
        do_reset();
        mode = 2'b10;
        step_btn = 1'b1;
        wait_state(3, 600);
        mode = 2'b01;
        cyc(1);
        @(negedge clk);
        check("modechg_idle", int'(state_o), 0);
        cyc(1);
        @(negedge clk);
        check("modechg_run", int'(state_o), 1);
        wait_rises(2, 200);
        cyc(4);
        @(negedge clk);
        check("modechg_stepped", int'(step_count > 4'd1), 1);
        cyc(1);
        mode = 2'b11;
        cyc(1);
        @(negedge clk);
        check("mode11_idle", int'(state_o), 0);
        wait_rises(3, 200);
        @(negedge clk);
        check("mode11_stays_idle", int'(state_o), 0);
        cyc(1);
        step_btn = 1'b0;

        // Saturation, then a one-cycle reset mid-run.
        do_reset();
        mode = 2'b01;
        wait_rises(20, 1000);
        cyc(4);
        @(negedge clk);
        check("sat_count_15", int'(step_count), 15);
        check("model_sat_count_15", m_count, 15);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", int'(step_count), 0);
        check("midrst_state", int'(state_o), 0);
        check("midrst_step_en", int'(step_en), 0);
        wait_rises(3, 200);

        // Random traffic on every input.
        repeat (4000) begin
            cyc(1);
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8) step_btn = ~step_btn;
            halted_in = ($urandom_range(0, 399) == 0);
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
        halted_in = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Sits directly downstream of the frequency divider that turns C_50Mhz into a 1 kHz square wave (toggles every 25_000 cycles).
- Brings that slow signal back into the C_50Mhz domain as single-cycle strobes.
- Uses the strobes to generate the processor's step enable in run mode or single-step mode, and to debounce the step pushbutton.
- Counts the steps it has issued and stops issuing them once the processor reports halt.

Parameters:
- CNT_W, 16: width of step_count.
- DEB_TICKS, 4: number of consecutive tick strobes (4 ms) for which the button level must be stable before the debounced level changes.
- DEB_W, 3: width of the debounce counter; must satisfy 2**DEB_W > DEB_TICKS.

Ports:
- C_50Mhz  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- tick_in  in  1  divider output (1 kHz square wave); asynchronous to C_50Mhz in phase.
- mode  in  2  00 = halt, 01 = run, 10 = single-step, 11 = reserved (treated as halt).
- step_btn  in  1  raw pushbutton, active-high, bouncing.
- halted_in  in  1  processor halt flag, synchronous to C_50Mhz.
- step_en  out  1  one-cycle enable for the processor to advance one step.
- step_count  out  CNT_W  number of step_en pulses issued since reset; saturating.
- state_o  out  3  current FSM state encoding.
- halted_o  out  1  high while in state HALTED.

Behaviour:
- Clock and reset: one clock, C_50Mhz; reset is synchronous and active-high (rst).
- Reset (rst high at a clock edge): all registers clear, including synchronizer flops.
  - step_en = 0, step_count = 0, halted_o = 0, state = IDLE (0).
  - Debounced button level = 0, debounce counter = 0.
  - Reset asserted mid-operation aborts any pending step; no step_en is issued during reset.
- Tick synchronizer: tick_in → ff1 → ff2 → prev; tick_pulse = ff2 & ~prev.
  - If tick_in is first sampled high at edge k, tick_pulse is high in the cycle after edge k+1.
  - Exactly one tick_pulse per tick_in rising edge; falling edges produce nothing.
- Button synchronizer: step_btn is 2-flop synchronized to btn_s.
- Debounce, evaluated only on tick_pulse cycles:
  - If btn_s ≠ debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEB_TICKS, the debounced level flips and the counter clears.
  - press = one-cycle pulse on a debounced 0→1 transition; release = the same for 1→0.
- FSM, all outputs registered:
  - IDLE (0): mode 01 → RUN; mode 10 → STEP_WAIT; otherwise stay.
  - RUN (1): on tick_pulse, step_en = 1 for one cycle (one cycle after tick_pulse). Mode ≠ 01 → IDLE.
  - STEP_WAIT (2): on press, step_en = 1 for one cycle and go to STEP_REL. Mode ≠ 10 → IDLE.
  - STEP_REL (3): on release → STEP_WAIT. Mode ≠ 10 → IDLE. Never issues step_en, so holding the button gives exactly one step.
  - HALTED (4): entered from any state except IDLE when halted_in = 1. Sticky; only rst leaves it. halted_o = 1, step_en = 0.
  - Encodings 5–7 are illegal and recover to IDLE on the next clock.
- Priority when events coincide: rst > halted_in > mode change > tick/press.
  - halted_in in the same cycle as tick_pulse in RUN → no step_en; go to HALTED.
  - A mode change in the same cycle as tick_pulse or press → no step_en; go to IDLE.
- step_count increments by 1 in the cycle step_en is asserted (visible the cycle after) and saturates at 2**CNT_W−1 (no wrap).
- Debounce logic keeps running in all states; the debounced level is valid regardless of mode.

Decomposition:
- Package step_pkg:
  - state_t enum {IDLE, RUN, STEP_WAIT, STEP_REL, HALTED}, 3 bits.
  - Mode constants MODE_HALT = 2'b00, MODE_RUN = 2'b01, MODE_STEP = 2'b10.
- Sub-module sync_edge: 2-flop synchronizer plus rising-edge detector. Ports C_50Mhz, rst, d, q (synced level), rise (one-cycle pulse).
  - Instantiated for tick_in.
  - For step_btn, only q is used.

Test Plan:
- Reset then run: rst 2 cycles, mode = 01, 1 kHz tick_in (toggle every 25_000 cycles) → exactly one step_en per tick_in rising edge, each 1 cycle wide, 50_000 cycles apart; step_count = 5 after 5 tick_in rising edges.
- Single-step with bounce: mode = 10, step_btn toggling every 100 cycles for 1 ms, then steady high for 6 ms, then low → exactly one step_en (≈4 ms after stable high, aligned to a tick); step_count = 1; state sequence 2→3→2.
- Button held: mode = 10, step_btn high for 50 ms → only one step_en; state stays 3 until the debounced release.
- Halt collision: mode = 01, halted_in raised in the same cycle as tick_pulse → no step_en; state = 4 and halted_o = 1 next cycle; mode changes are then ignored until rst.
- Mode change mid-step: in STEP_REL, switch mode to 01 → IDLE next cycle, then RUN the cycle after; next tick gives step_en. mode = 11 in RUN → IDLE, no steps.
- Saturation / reset mid-run: CNT_W = 4, run 20 ticks → step_count holds at 15. rst asserted for 1 cycle mid-run → step_count = 0, state = 0, step_en = 0 the next cycle.
